result_frame_scheduler: RTL and testbench

//  Collects completed results from the position demodulator (x1,i1,x2,i2 on pos_done) and the
//  OPD lock-in (x,y on opd_done) and serialises them as tagged frames onto one 32-bit

---
 rtl/result_frame_scheduler.sv | 168 ++++++++++++++++
 tb/tb_result_frame_scheduler.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/result_frame_scheduler.sv
// Result frame scheduler: captures POS/OPD results into holding slots and
// serialises them as tagged frames on a 32-bit valid/ready word stream.
module result_frame_scheduler #(
    parameter int DATA_W = 24,
    parameter int SEQ_W  = 30,
    parameter int DROP_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable_i,
    input  logic              pos_done_i,
    input  logic [DATA_W-1:0] pos_x1_i,
    input  logic [DATA_W-1:0] pos_i1_i,
    input  logic [DATA_W-1:0] pos_x2_i,
    input  logic [DATA_W-1:0] pos_i2_i,
    input  logic              opd_done_i,
    input  logic [DATA_W-1:0] opd_x_i,
    input  logic [DATA_W-1:0] opd_y_i,
    output logic [31:0]       m_data_o,
    output logic              m_valid_o,
    output logic              m_last_o,
    input  logic              m_ready_i,
    output logic [SEQ_W-1:0]  pos_seq_o,
    output logic [SEQ_W-1:0]  opd_seq_o,
    output logic [DROP_W-1:0] pos_drop_o,
    output logic [DROP_W-1:0] opd_drop_o,
    output logic              busy_o
);

    typedef enum logic [1:0] {S_IDLE, S_HDR, S_PAY} state_t;

    state_t r_state;
    state_t w_next;

    logic [DATA_W-1:0] r_pos_pay [4];
    logic [SEQ_W-1:0]  r_pos_seq;
    logic              r_pos_pend;
    logic [DATA_W-1:0] r_opd_pay [2];
    logic [SEQ_W-1:0]  r_opd_seq;
    logic              r_opd_pend;
    logic [SEQ_W-1:0]  r_pos_cnt;
    logic [SEQ_W-1:0]  r_opd_cnt;
    logic [DROP_W-1:0] r_pos_drop;
    logic [DROP_W-1:0] r_opd_drop;
    logic              r_last_opd;

    logic              r_tx_opd;
    logic [SEQ_W-1:0]  r_tx_seq;
    logic [31:0]       r_tx_w [4];
    logic [1:0]        r_idx;

    logic              w_grant_pos;
    logic              w_grant_opd;
    logic [1:0]        w_last_idx;
    logic [31:0]       w_hdr;

    function automatic logic [31:0] sx(input logic [DATA_W-1:0] v);
        return {{(32-DATA_W){v[DATA_W-1]}}, v};
    endfunction

    // Tie goes to the source that was not served last.
    assign w_grant_pos = (r_state == S_IDLE) && r_pos_pend && (!r_opd_pend || r_last_opd);
    assign w_grant_opd = (r_state == S_IDLE) && r_opd_pend && (!r_pos_pend || !r_last_opd);
    assign w_last_idx  = r_tx_opd ? 2'd1 : 2'd3;
    assign w_hdr       = {(r_tx_opd ? 2'b10 : 2'b01), 30'(r_tx_seq)};

    assign pos_seq_o  = r_pos_cnt;
    assign opd_seq_o  = r_opd_cnt;
    assign pos_drop_o = r_pos_drop;
    assign opd_drop_o = r_opd_drop;

    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next    = r_state;
        m_valid_o = 1'b0;
        m_data_o  = '0;
        m_last_o  = 1'b0;
        busy_o    = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (w_grant_pos || w_grant_opd) w_next = S_HDR;
            end
            S_HDR: begin
                m_valid_o = 1'b1;
                busy_o    = 1'b1;
                m_data_o  = w_hdr;
                if (m_ready_i) w_next = S_PAY;
            end
            S_PAY: begin
                m_valid_o = 1'b1;
                busy_o    = 1'b1;
                m_data_o  = r_tx_w[r_idx];
                m_last_o  = (r_idx == w_last_idx);
                if (m_ready_i && (r_idx == w_last_idx)) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // A slot freed by a grant in the same cycle can take a new capture.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pos_pay  <= '{default: '0};
            r_pos_seq  <= '0;
            r_pos_pend <= 1'b0;
            r_opd_pay  <= '{default: '0};
            r_opd_seq  <= '0;
            r_opd_pend <= 1'b0;
            r_pos_cnt  <= '0;
            r_opd_cnt  <= '0;
            r_pos_drop <= '0;
            r_opd_drop <= '0;
        end else begin
            if (w_grant_pos) r_pos_pend <= 1'b0;
            if (w_grant_opd) r_opd_pend <= 1'b0;
            if (pos_done_i && enable_i) begin
                if (!r_pos_pend || w_grant_pos) begin
                    r_pos_pay  <= '{pos_x1_i, pos_i1_i, pos_x2_i, pos_i2_i};
                    r_pos_seq  <= r_pos_cnt;
                    r_pos_cnt  <= r_pos_cnt + 1'b1;
                    r_pos_pend <= 1'b1;
                end else if (r_pos_drop != '1) begin
                    r_pos_drop <= r_pos_drop + 1'b1;
                end
            end
            if (opd_done_i && enable_i) begin
                if (!r_opd_pend || w_grant_opd) begin
                    r_opd_pay  <= '{opd_x_i, opd_y_i};
                    r_opd_seq  <= r_opd_cnt;
                    r_opd_cnt  <= r_opd_cnt + 1'b1;
                    r_opd_pend <= 1'b1;
                end else if (r_opd_drop != '1) begin
                    r_opd_drop <= r_opd_drop + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_tx_opd   <= 1'b0;
            r_tx_seq   <= '0;
            r_tx_w     <= '{default: '0};
            r_idx      <= '0;
            r_last_opd <= 1'b1;
        end else if (w_grant_pos) begin
            r_tx_opd   <= 1'b0;
            r_tx_seq   <= r_pos_seq;
            r_tx_w     <= '{sx(r_pos_pay[0]), sx(r_pos_pay[1]),
                            sx(r_pos_pay[2]), sx(r_pos_pay[3])};
            r_idx      <= '0;
            r_last_opd <= 1'b0;
        end else if (w_grant_opd) begin
            r_tx_opd   <= 1'b1;
            r_tx_seq   <= r_opd_seq;
            r_tx_w     <= '{sx(r_opd_pay[0]), sx(r_opd_pay[1]), 32'd0, 32'd0};
            r_idx      <= '0;
            r_last_opd <= 1'b1;
        end else if (r_state == S_PAY && m_ready_i) begin
            r_idx <= r_idx + 1'b1;
        end
    end

endmodule

// File: tb/tb_result_frame_scheduler.sv
// Randomised and directed bench for result_frame_scheduler against a
// frame-queue reference model.
module tb_result_frame_scheduler;

    localparam int DW   = 5;
    localparam int DMAX = (1 << DW) - 1;

    logic          clk;
    logic          reset;
    logic          enable_i;
    logic          pos_done_i;
    logic [23:0]   pos_x1_i, pos_i1_i, pos_x2_i, pos_i2_i;
    logic          opd_done_i;
    logic [23:0]   opd_x_i, opd_y_i;
    logic [31:0]   m_data_o;
    logic          m_valid_o;
    logic          m_last_o;
    logic          m_ready_i;
    logic [29:0]   pos_seq_o, opd_seq_o;
    logic [DW-1:0] pos_drop_o, opd_drop_o;
    logic          busy_o;

    int n_vec = 0;
    int n_err = 0;

    logic [29:0] mseq [2];
    logic [29:0] sseq [2];
    bit          pend [2];
    logic [31:0] spay [2][4];
    int          mdrop [2];
    int          lastg;
    logic [31:0] q [$];

    result_frame_scheduler #(.DATA_W(24), .SEQ_W(30), .DROP_W(DW)) dut (
        .clk(clk), .reset(reset), .enable_i(enable_i),
        .pos_done_i(pos_done_i), .pos_x1_i(pos_x1_i), .pos_i1_i(pos_i1_i),
        .pos_x2_i(pos_x2_i), .pos_i2_i(pos_i2_i),
        .opd_done_i(opd_done_i), .opd_x_i(opd_x_i), .opd_y_i(opd_y_i),
        .m_data_o(m_data_o), .m_valid_o(m_valid_o), .m_last_o(m_last_o),
        .m_ready_i(m_ready_i), .pos_seq_o(pos_seq_o), .opd_seq_o(opd_seq_o),
        .pos_drop_o(pos_drop_o), .opd_drop_o(opd_drop_o), .busy_o(busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            if (n_err <= 30)
                $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [31:0] sx(input logic [23:0] v);
        return {{8{v[23]}}, v};
    endfunction

    task automatic model_clear();
        for (int s = 0; s < 2; s++) begin
            mseq[s] = '0; sseq[s] = '0; pend[s] = 0; mdrop[s] = 0;
            for (int k = 0; k < 4; k++) spay[s][k] = '0;
        end
        lastg = 1;
        q.delete();
    endtask

    task automatic model_edge(input bit pd, od, rdy, en, rst);
        int g;
        int n;
        bit dn [2];
        logic [1:0] tg;
        if (rst) begin
            model_clear();
            return;
        end
        g = -1;
        if (q.size() == 0) begin
            if (pend[0] && pend[1]) g = (lastg == 0) ? 1 : 0;
            else if (pend[0])       g = 0;
            else if (pend[1])       g = 1;
            if (g >= 0) begin
                tg = (g == 0) ? 2'b01 : 2'b10;
                n  = (g == 0) ? 4 : 2;
                q.push_back({tg, sseq[g]});
                for (int k = 0; k < n; k++) q.push_back(spay[g][k]);
                pend[g] = 0;
                lastg   = g;
            end
        end else if (rdy) begin
            void'(q.pop_front());
        end
        dn[0] = pd && en;
        dn[1] = od && en;
        for (int s = 0; s < 2; s++) begin
            if (dn[s]) begin
                if (!pend[s]) begin
                    pend[s] = 1;
                    sseq[s] = mseq[s];
                    mseq[s] = mseq[s] + 1;
                    if (s == 0) begin
                        spay[0][0] = sx(pos_x1_i); spay[0][1] = sx(pos_i1_i);
                        spay[0][2] = sx(pos_x2_i); spay[0][3] = sx(pos_i2_i);
                    end else begin
                        spay[1][0] = sx(opd_x_i);  spay[1][1] = sx(opd_y_i);
                    end
                end else if (mdrop[s] < DMAX) begin
                    mdrop[s]++;
                end
            end
        end
    endtask

    task automatic check_outputs();
        check("valid", m_valid_o, q.size() != 0);
        check("busy", busy_o, q.size() != 0);
        if (q.size() != 0) begin
            check("data", m_data_o, q[0]);
            check("last", m_last_o, q.size() == 1);
        end
        check("pos_seq", pos_seq_o, mseq[0]);
        check("opd_seq", opd_seq_o, mseq[1]);
        check("pos_drop", pos_drop_o, mdrop[0]);
        check("opd_drop", opd_drop_o, mdrop[1]);
    endtask

    task automatic step(input bit pd, od, rdy, en, rst);
        pos_done_i = pd;
        opd_done_i = od;
        m_ready_i  = rdy;
        enable_i   = en;
        reset      = rst;
        check_outputs();
        @(posedge clk);
        model_edge(pd, od, rdy, en, rst);
        #1;
    endtask

    task automatic rnd_pay();
        pos_x1_i = 24'($urandom); pos_i1_i = 24'($urandom);
        pos_x2_i = 24'($urandom); pos_i2_i = 24'($urandom);
        opd_x_i  = 24'($urandom); opd_y_i  = 24'($urandom);
    endtask

    logic [31:0] exp1 [5];

    initial begin
        reset = 1'b1; enable_i = 1'b1; m_ready_i = 1'b1;
        pos_done_i = 1'b0; opd_done_i = 1'b0;
        rnd_pay();
        repeat (2) @(posedge clk);
        #1;
        model_clear();
        check("rst_valid", m_valid_o, 1'b0);
        check("rst_data", m_data_o, 32'd0);
        step(0, 0, 1, 1, 0);

        // single POS frame with known payload
        pos_x1_i = 24'hFFFFFF; pos_i1_i = 24'd5;
        pos_x2_i = 24'd7;      pos_i2_i = 24'hFFFFF8;
        exp1 = '{32'h40000000, 32'hFFFFFFFF, 32'h5, 32'h7, 32'hFFFFFFF8};
        step(1, 0, 1, 1, 0);
        step(0, 0, 1, 1, 0);
        for (int k = 0; k < 5; k++) begin
            check("t1_word", m_data_o, exp1[k]);
            check("t1_last", m_last_o, k == 4);
            step(0, 0, 1, 1, 0);
        end

        // simultaneous POS and OPD: POS first, OPD header after one gap
        step(0, 0, 1, 1, 1);
        rnd_pay();
        step(1, 1, 1, 1, 0);
        step(0, 0, 1, 1, 0);
        check("t2_pos_hdr", m_data_o, 32'h40000000);
        repeat (6) step(0, 0, 1, 1, 0);
        check("t2_opd_hdr", m_data_o, 32'h80000000);
        repeat (4) step(0, 0, 1, 1, 0);
        rnd_pay();
        step(1, 1, 1, 1, 0);
        repeat (12) step(0, 0, 1, 1, 0);

        // consumer stalled: one frame in flight, one slot held, rest dropped
        step(0, 0, 1, 1, 1);
        for (int c = 0; c < 100; c++) begin
            rnd_pay();
            step((c % 10) == 0 && c < 30, 0, 0, 1, 0);
        end
        check("t3_seq", pos_seq_o, 30'd2);
        check("t3_drop", pos_drop_o, 1);
        for (int c = 0; c < 40; c++) begin
            rnd_pay();
            step(1, 1, 0, 1, 0);
        end
        check("t3_drop_sat", pos_drop_o, DMAX);
        repeat (20) step(0, 0, 1, 1, 0);

        // done on the grant cycle is captured
        step(0, 0, 1, 1, 1);
        rnd_pay();
        step(1, 0, 1, 1, 0);
        rnd_pay();
        step(1, 0, 1, 1, 0);
        check("t4_drop", pos_drop_o, 0);
        repeat (6) step(0, 0, 1, 1, 0);
        check("t4_hdr2", m_data_o, 32'h40000001);
        repeat (6) step(0, 0, 1, 1, 0);

        // enable low ignores captures
        step(0, 0, 1, 1, 1);
        for (int c = 0; c < 10; c++) step(0, 1, 1, 0, 0);
        check("t5_seq", opd_seq_o, 30'd0);
        check("t5_valid", m_valid_o, 1'b0);
        step(0, 1, 1, 1, 0);
        repeat (5) step(0, 0, 1, 1, 0);
        check("t5_seq2", opd_seq_o, 30'd1);

        // reset during the third payload word
        step(0, 0, 1, 1, 1);
        step(1, 0, 1, 1, 0);
        repeat (4) step(0, 0, 1, 1, 0);
        check("t6_mid", m_valid_o, 1'b1);
        step(0, 0, 1, 1, 1);
        check("t6_valid", m_valid_o, 1'b0);
        check("t6_seq", pos_seq_o, 30'd0);
        step(1, 0, 1, 1, 0);
        step(0, 0, 1, 1, 0);
        check("t6_hdr", m_data_o, 32'h40000000);

        // randomised traffic
        for (int c = 0; c < 3000; c++) begin
            rnd_pay();
            step($urandom_range(3) == 0, $urandom_range(3) == 0,
                 $urandom_range(3) != 0, $urandom_range(9) != 0,
                 $urandom_range(499) == 0);
        end
        repeat (20) step(0, 0, 1, 1, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
